// File: rtl/led_fade_driver.sv
// led_fade_driver
// ----------------------------------------------------------------------------
// Per-LED PWM output stage that fades every LED smoothly towards the on/off
// target pattern produced by the upstream animation state machine.
//
// A free-running PWM counter defines frames of 2^PWM_BITS clocks. Every
// FADE_FRAMES frames, each channel's duty moves one STEP towards its target
// level. A target of 1 ramps towards full on and a target of 0 ramps towards
// off, saturating at both ends.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           output enable; 0 forces every LED pin low (fading continues)
//   pattern_in   target on/off pattern, one bit per LED
//   pattern_vld  single-cycle strobe that latches pattern_in as the new target
//   led_out      registered PWM drive, one bit per LED
//   frame_tick   one-cycle pulse while the PWM counter sits at 0 after a wrap
//   busy         registered; high while any duty differs from its target level
// ----------------------------------------------------------------------------
module led_fade_driver #(
    parameter int N_LED       = 8,
    parameter int PWM_BITS    = 8,
    parameter int FADE_FRAMES = 4,
    parameter int STEP        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_LED-1:0] pattern_in,
    input  logic             pattern_vld,
    output logic [N_LED-1:0] led_out,
    output logic             frame_tick,
    output logic             busy
);

    localparam int                  P1         = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] MAX        = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP_D     = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   STEP_W     = P1'(STEP);
    localparam logic [7:0]          LAST_FRAME = 8'(FADE_FRAMES - 1);

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                frame_tick_reg;
    logic [7:0]          frame_cnt_reg;
    logic                step_en;
    logic [N_LED-1:0]    tgt_reg;
    logic [N_LED-1:0]    led_reg;
    logic                busy_reg;
    logic [N_LED-1:0]    raw;
    logic [N_LED-1:0]    mismatch;

    // PWM counter and frame tick. The tick is registered from the MAX count,
    // so it is high exactly while the counter reads 0 after a wrap (never in
    // the first frame straight out of reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_reg    <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            pwm_cnt_reg    <= pwm_cnt_reg + PWM_BITS'(1);
            frame_tick_reg <= (pwm_cnt_reg == MAX);
        end
    end

    // Frame counter: counts frame ticks 0..FADE_FRAMES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (frame_tick_reg) begin
            frame_cnt_reg <= (frame_cnt_reg == LAST_FRAME) ? 8'd0 : frame_cnt_reg + 8'd1;
        end
    end

    // Brightness steps only happen on a frame tick, so a PWM frame is never
    // cut mid-period by a duty change.
    assign step_en = frame_tick_reg && (frame_cnt_reg == LAST_FRAME);

    // Target latch. A strobe coinciding with step_en does not affect that
    // step: the duty logic reads the register value from before the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_reg <= '0;
        end else if (pattern_vld) begin
            tgt_reg <= pattern_in;
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
        logic [PWM_BITS-1:0] duty_reg;
        logic [PWM_BITS-1:0] duty_next;
        logic [PWM_BITS:0]   sum;

        // Saturating step towards the target level. The increment is done
        // one bit wider so that the carry flags an overshoot of MAX.
        always_comb begin
            sum       = {1'b0, duty_reg} + STEP_W;
            duty_next = duty_reg;
            if (tgt_reg[gi]) begin
                duty_next = sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0];
            end else begin
                duty_next = (duty_reg < STEP_D) ? '0 : duty_reg - STEP_D;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_reg <= '0;
            end else if (step_en) begin
                duty_reg <= duty_next;
            end
        end

        // Full duty is a steady 100 % rather than MAX/(MAX+1).
        assign raw[gi]      = (duty_reg == MAX) || (pwm_cnt_reg < duty_reg);
        assign mismatch[gi] = tgt_reg[gi] ? (duty_reg != MAX) : (duty_reg != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg  <= '0;
            busy_reg <= 1'b0;
        end else begin
            led_reg  <= en ? raw : '0;
            busy_reg <= |mismatch;
        end
    end

    assign led_out    = led_reg;
    assign frame_tick = frame_tick_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver
// ----------------------------------------------------------------------------
// Self-checking bench for led_fade_driver. A small instance (PWM_BITS=4,
// FADE_FRAMES=2, STEP=5) is compared against a time-indexed reference model
// and against hand-derived per-frame brightness counts; a default-parameter
// instance checks the frame tick period and the brightness step interval.
// ----------------------------------------------------------------------------
module tb_led_fade_driver;

    localparam int PB        = 4;
    localparam int FF        = 2;
    localparam int ST        = 5;
    localparam int MAXV      = 15;
    localparam int M         = 16;
    localparam int STEP_CLKS = FF * M;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pattern_in;
    logic       pattern_vld;
    logic [7:0] led_out;
    logic       frame_tick;
    logic       busy;
    logic [7:0] led_def;
    logic       ft_def;
    logic       busy_def;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fade_driver #(.N_LED(8), .PWM_BITS(PB), .FADE_FRAMES(FF), .STEP(ST)) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_in(pattern_in), .pattern_vld(pattern_vld),
        .led_out(led_out), .frame_tick(frame_tick), .busy(busy)
    );

    led_fade_driver dut_def (
        .clk(clk), .rst(rst), .en(en), .pattern_in(pattern_in), .pattern_vld(pattern_vld),
        .led_out(led_def), .frame_tick(ft_def), .busy(busy_def)
    );

    // ---------------- reference model (small instance) ----------------
    // m_t is the number of clock edges since reset release; the PWM position
    // is m_t mod M and a brightness step lands on every nonzero multiple of
    // FF*M edges.
    int         m_t;
    int         m_duty [8];
    logic [7:0] m_tgt;
    logic [7:0] exp_led;
    logic       exp_busy;
    logic       exp_ft;

    function automatic logic [7:0] model_led(input int t, input logic e);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i] = e && (m_duty[i] == MAXV || (t % M) < m_duty[i]);
        return r;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++)
            if (m_duty[i] != (m_tgt[i] ? MAXV : 0)) b = 1'b1;
        return b;
    endfunction

    function automatic int model_step(input int d, input logic up);
        if (up) return (d + ST > MAXV) ? MAXV : d + ST;
        return (d - ST < 0) ? 0 : d - ST;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_tgt    <= '0;
            exp_led  <= '0;
            exp_busy <= 1'b0;
            exp_ft   <= 1'b0;
            for (int i = 0; i < 8; i++) m_duty[i] <= 0;
        end else begin
            exp_led  <= model_led(m_t, en);
            exp_busy <= model_busy();
            exp_ft   <= ((m_t + 1) % M) == 0;
            if (m_t > 0 && m_t % STEP_CLKS == 0)
                for (int i = 0; i < 8; i++) m_duty[i] <= model_step(m_duty[i], m_tgt[i]);
            if (pattern_vld) m_tgt <= pattern_in;
            m_t <= m_t + 1;
        end
    end

    // ---------------- window sampler ----------------
    // A window is the 16 (or 256) led samples covering PWM slots 1..MAX and
    // then slot 0 of the following frame; all of them see the same duty, so
    // the count of high samples equals the duty (MAX+1 at full duty).
    int   win_cnt [16][8];
    logic win_busy_first [16];
    logic win_busy_last  [16];

    task automatic collect(input int nw, input bit use_def, input bit aligned);
        int         wsize;
        int         guard;
        logic [7:0] lv;
        wsize = use_def ? 256 : 16;
        for (int w = 0; w < 16; w++) begin
            win_busy_first[w] = 1'b0;
            win_busy_last[w]  = 1'b0;
            for (int c = 0; c < 8; c++) win_cnt[w][c] = 0;
        end
        if (!aligned) begin
            guard = 0;
            do begin
                @(negedge clk);
                pattern_vld = 1'b0;
                guard++;
            end while (!(use_def ? ft_def : frame_tick) && guard < 1000);
            n_checks++;
            if (guard >= 1000) begin
                n_fail++;
                $display("FAIL collect_tick_timeout: no frame_tick within %0d cycles, required one", guard);
            end
            @(negedge clk);
            pattern_vld = 1'b0;
        end
        for (int w = 0; w < nw; w++) begin
            for (int s = 0; s < wsize; s++) begin
                @(negedge clk);
                pattern_vld = 1'b0;
                lv = use_def ? led_def : led_out;
                for (int c = 0; c < 8; c++) if (lv[c]) win_cnt[w][c]++;
                if (s == 0)         win_busy_first[w] = use_def ? busy_def : busy;
                if (s == wsize - 1) win_busy_last[w]  = use_def ? busy_def : busy;
            end
        end
    endtask

    // Parks at the negedge of a cycle in which step_en is active.
    task automatic wait_step_tick();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(m_t > 0 && m_t % STEP_CLKS == 0) && guard < 200);
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL step_tick_timeout: waited %0d cycles, required < 200", guard);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; pattern_in = '0; pattern_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({led_out, frame_tick, busy} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: led=%h tick=%b busy=%b, required all 0", led_out, frame_tick, busy);
        end
        n_checks++;
        if ({led_def, ft_def, busy_def} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state_def: led=%h tick=%b busy=%b, required all 0", led_def, ft_def, busy_def);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, frame_tick, busy} !== {exp_led, exp_ft, exp_busy}) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: led=%h tick=%b busy=%b, required led=%h tick=%b busy=%b",
                         i, led_out, frame_tick, busy, exp_led, exp_ft, exp_busy);
            end
        end
    endtask

    task automatic test_fade_in();
        int j0;
        int others;
        @(negedge clk);
        pattern_in = 8'h01; pattern_vld = 1'b1;
        @(negedge clk);
        pattern_vld = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fade_in_busy_lag: busy=%b one clk after strobe, required 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fade_in_busy_rise: busy=%b, required 1", busy);
        end
        collect(10, 1'b0, 1'b0);
        j0 = -1;
        for (int w = 9; w >= 0; w--) if (win_cnt[w][0] != 0) j0 = w;
        n_checks++;
        if (j0 < 0 || j0 > 4) begin
            n_fail++;
            $display("FAIL fade_in_start: first lit window %0d, required 0..4", j0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (win_cnt[j0 + k][0] !== ((k < 2) ? 5 : (k < 4) ? 10 : 16)) begin
                    n_fail++;
                    $display("FAIL fade_in_level step %0d: on %0d of 16, required %0d",
                             k, win_cnt[j0 + k][0], (k < 2) ? 5 : (k < 4) ? 10 : 16);
                end
            end
            n_checks++;
            if ({win_busy_last[j0 + 3], win_busy_first[j0 + 4]} !== 2'b10) begin
                n_fail++;
                $display("FAIL fade_in_busy_fall: busy before/after full=%b%b, required 10",
                         win_busy_last[j0 + 3], win_busy_first[j0 + 4]);
            end
        end
        others = 0;
        for (int w = 0; w < 10; w++) for (int c = 1; c < 8; c++) others += win_cnt[w][c];
        n_checks++;
        if (others !== 0) begin
            n_fail++;
            $display("FAIL fade_in_others: %0d high samples on LEDs 7..1, required 0", others);
        end
    endtask

    task automatic test_fade_out();
        int j0;
        int req;
        @(negedge clk);
        pattern_in = 8'h00; pattern_vld = 1'b1;
        collect(12, 1'b0, 1'b0);
        j0 = -1;
        for (int w = 11; w >= 0; w--) if (win_cnt[w][0] != 16) j0 = w;
        n_checks++;
        if (j0 < 0 || j0 > 4) begin
            n_fail++;
            $display("FAIL fade_out_start: first dimmed window %0d, required 0..4", j0);
        end else begin
            for (int k = 0; k < 8; k++) begin
                req = (k < 2) ? 10 : (k < 4) ? 5 : 0;
                n_checks++;
                if (win_cnt[j0 + k][0] !== req) begin
                    n_fail++;
                    $display("FAIL fade_out_level step %0d: on %0d of 16, required %0d",
                             k, win_cnt[j0 + k][0], req);
                end
            end
            n_checks++;
            if ({win_busy_last[j0 + 3], win_busy_first[j0 + 4]} !== 2'b10) begin
                n_fail++;
                $display("FAIL fade_out_busy_fall: busy before/after off=%b%b, required 10",
                         win_busy_last[j0 + 3], win_busy_first[j0 + 4]);
            end
        end
    endtask

    task automatic test_collision();
        int req;
        wait_step_tick();
        pattern_in = 8'hFF; pattern_vld = 1'b1;
        @(negedge clk);
        pattern_vld = 1'b0;
        collect(3, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            req = (w < 2) ? 0 : 5;
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (win_cnt[w][c] !== req) begin
                    n_fail++;
                    $display("FAIL collision_level win %0d led %0d: on %0d, required %0d", w, c, win_cnt[w][c], req);
                end
            end
        end
        n_checks++;
        if (win_busy_first[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_busy: busy=%b, required 1", win_busy_first[0]);
        end
        pattern_in = 8'h00; pattern_vld = 1'b1;
        collect(3, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            req = (w == 0) ? 5 : 0;
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (win_cnt[w][c] !== req) begin
                    n_fail++;
                    $display("FAIL reversal_level win %0d led %0d: on %0d, required %0d", w, c, win_cnt[w][c], req);
                end
            end
        end
        n_checks++;
        if (win_busy_first[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reversal_busy: busy=%b, required 0", win_busy_first[1]);
        end
    endtask

    task automatic test_enable();
        wait_step_tick();
        pattern_in = 8'hFF; pattern_vld = 1'b1; en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pattern_vld = 1'b0;
            n_checks++;
            if (led_out !== 8'h00 || busy !== exp_busy || frame_tick !== exp_ft) begin
                n_fail++;
                $display("FAIL enable_off cyc %0d: led=%h busy=%b tick=%b, required led=00 busy=%b tick=%b",
                         i, led_out, busy, frame_tick, exp_busy, exp_ft);
            end
        end
        en = 1'b1;
        collect(2, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (win_cnt[1][c] !== 16) begin
                n_fail++;
                $display("FAIL enable_resume led %0d: on %0d of 16, required 16", c, win_cnt[1][c]);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        int guard;
        @(negedge clk);
        pattern_in = 8'h00; pattern_vld = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            pattern_vld = 1'b0;
            guard++;
        end while (m_duty[0] != 10 && guard < 200);
        @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre_busy: busy=%b mid-ramp, required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({led_out, frame_tick, busy, led_def, ft_def, busy_def} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: led=%h tick=%b busy=%b def led=%h tick=%b busy=%b, required all 0",
                     led_out, frame_tick, busy, led_def, ft_def, busy_def);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({led_out, frame_tick, busy} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: led=%h tick=%b busy=%b, required all 0", led_out, frame_tick, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, frame_tick, busy} !== {exp_led, exp_ft, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc %0d: led=%h tick=%b busy=%b, required led=%h tick=%b busy=%b",
                         i, led_out, frame_tick, busy, exp_led, exp_ft, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++;
            if ({led_out, frame_tick, busy} !== {exp_led, exp_ft, exp_busy}) begin
                n_fail++;
                $display("FAIL random cyc %0d: led=%h tick=%b busy=%b, required led=%h tick=%b busy=%b",
                         i, led_out, frame_tick, busy, exp_led, exp_ft, exp_busy);
            end
            pattern_vld = ($urandom_range(0, 39) == 0);
            pattern_in  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) en = ~en;
        end
        @(negedge clk);
        pattern_vld = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_frame_tick();
        int cyc;
        int ticks;
        int j;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; pattern_in = 8'h01; pattern_vld = 1'b1;
        cyc = 0; ticks = 0;
        while (ticks < 3 && cyc < 2000) begin
            @(negedge clk);
            pattern_vld = 1'b0;
            cyc++;
            if (ft_def) begin
                n_checks++;
                if (cyc !== 256 * (ticks + 1)) begin
                    n_fail++;
                    $display("FAIL frame_tick_period: tick at cycle %0d, required %0d", cyc, 256 * (ticks + 1));
                end
                ticks++;
            end
        end
        n_checks++;
        if (ticks !== 3) begin
            n_fail++;
            $display("FAIL frame_tick_count: %0d ticks in %0d cycles, required 3", ticks, cyc);
        end
        collect(14, 1'b1, 1'b0);
        j = -1;
        for (int w = 13; w >= 1; w--) if (win_cnt[w][0] != win_cnt[w - 1][0]) j = w;
        n_checks++;
        if (j < 1 || j > 5) begin
            n_fail++;
            $display("FAIL step_interval_start: first change at window %0d, required 1..5", j);
        end else begin
            n_checks++;
            if (win_cnt[j][0] - win_cnt[j - 1][0] !== 8) begin
                n_fail++;
                $display("FAIL step_size: duty rose by %0d, required 8", win_cnt[j][0] - win_cnt[j - 1][0]);
            end
            for (int k = 1; k < 9; k++) begin
                n_checks++;
                if (win_cnt[j + k][0] !== win_cnt[j][0] + 8 * (k / 4)) begin
                    n_fail++;
                    $display("FAIL step_interval win +%0d: on %0d of 256, required %0d",
                             k, win_cnt[j + k][0], win_cnt[j][0] + 8 * (k / 4));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_fade_out();
        test_collision();
        test_enable();
        test_reset_mid_ramp();
        test_random();
        test_frame_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
